// File: rtl/hazard_ctrl.sv
// Decode-stage hazard and stall controller.
// Detects load-use hazards against the instruction in EX and drives the
// ID/EX bubble plus the PC / IF/ID hold enables. Also sequences a halt
// drain and keeps a saturating count of stalled cycles.
module hazard_ctrl #(
    parameter int REG_WORDS    = 32,
    parameter int ADDR_LEFT    = $clog2(REG_WORDS) - 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_BITS     = 16
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic [ADDR_LEFT:0]  r1_addr,
    input  logic [ADDR_LEFT:0]  r2_addr,
    input  logic                r1_used,
    input  logic                r2_used,
    input  logic [ADDR_LEFT:0]  waddr_s3,
    input  logic                rw_s3,
    input  logic                sel_mem_s3,
    input  logic                halt_s2,
    input  logic                ext_stall,
    input  logic                cnt_clr,
    output logic                stall_pipe,
    output logic                hold_pc,
    output logic                hold_if_id,
    output logic                halted,
    output logic [CNT_BITS-1:0] stall_cnt
);

    // A drain length of 0 behaves like 1: at least one cycle in DRAIN.
    localparam int DRAIN_LOAD = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
    localparam int DW         = $clog2(DRAIN_LOAD + 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_LOAD);
    localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic          hz;
    logic          stall_c;
    logic          halted_c;

    // Load-use hazard: a load in EX writing a nonzero register that ID reads.
    always_comb begin
        hz = sel_mem_s3 && !rw_s3 && (waddr_s3 != '0) &&
             ((r1_used && (r1_addr == waddr_s3)) ||
              (r2_used && (r2_addr == waddr_s3)));
    end

    // Next-state and stall decisions for RUN / DRAIN / HALTED.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_nxt = state;
        drain_nxt = drain_cnt;
        stall_c   = 1'b0;
        halted_c  = 1'b0;
        case (state)
            RUN: begin
                stall_c = hz || ext_stall;
                // A stall wins over halt; the halt is retried next cycle.
                if (halt_s2 && !stall_c) begin
                    state_nxt = DRAIN;
                    drain_nxt = DRAIN_INIT;
                end
            end
            DRAIN: begin
                stall_c   = 1'b1;
                drain_nxt = drain_cnt - DRAIN_ONE;
                if (drain_cnt <= DRAIN_ONE) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                stall_c  = 1'b1;
                halted_c = 1'b1;
            end
            default: begin
                state_nxt = RUN;
                drain_nxt = '0;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is held.
    always_comb begin
        stall_pipe = rst_ && stall_c;
        hold_pc    = rst_ && stall_c;
        hold_if_id = rst_ && stall_c;
        halted     = rst_ && halted_c;
    end

    // State and drain counter registers.
    always_ff @(posedge clk or negedge rst_) begin
        // NOTE: reset values are applied asynchronously so a reset landing
        // mid-drain discards the partial drain without waiting for a clock.
        if (!rst_) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating
            // from pre-edge values, independent of statement order.
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    // Saturating count of stalled RUN cycles; clear beats increment.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if ((state == RUN) && stall_c && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a timestamp-based behavioural model
// checked every cycle, plus directed sequences with literal expectations.
module tb_hazard_ctrl;

    localparam int D    = 3;
    localparam int MAXC = 65535;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic [4:0]  r1_addr = '0, r2_addr = '0, waddr_s3 = '0;
    logic        r1_used = 1'b0, r2_used = 1'b0;
    logic        rw_s3 = 1'b1, sel_mem_s3 = 1'b0;
    logic        halt_s2 = 1'b0, ext_stall = 1'b0, cnt_clr = 1'b0;
    logic        stall_pipe, hold_pc, hold_if_id, halted;
    logic [15:0] stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    hazard_ctrl #(
        .REG_WORDS(32), .DRAIN_CYCLES(D), .CNT_BITS(16)
    ) dut (
        .clk(clk), .rst_(rst_),
        .r1_addr(r1_addr), .r2_addr(r2_addr),
        .r1_used(r1_used), .r2_used(r2_used),
        .waddr_s3(waddr_s3), .rw_s3(rw_s3), .sel_mem_s3(sel_mem_s3),
        .halt_s2(halt_s2), .ext_stall(ext_stall), .cnt_clr(cnt_clr),
        .stall_pipe(stall_pipe), .hold_pc(hold_pc), .hold_if_id(hold_if_id),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the halt is accepted at cycle m_halt_at; the front end stalls for
    // the next max(D,1) cycles and is halted from then on.
    int m_cyc = 0;
    int m_halt_at = -1;
    int m_cnt = 0;

    always @(negedge clk) begin
        bit hz, running, e_stall, e_halted;
        if (!rst_) begin
            check("rst_stall_pipe", {31'd0, stall_pipe}, 0);
            check("rst_halted", {31'd0, halted}, 0);
            check("rst_stall_cnt", {16'd0, stall_cnt}, 0);
            m_cyc = 0; m_halt_at = -1; m_cnt = 0;
        end else begin
            hz = sel_mem_s3 && !rw_s3 && (waddr_s3 != 0) &&
                 ((r1_used && r1_addr == waddr_s3) || (r2_used && r2_addr == waddr_s3));
            running  = (m_halt_at < 0) || (m_cyc <= m_halt_at);
            e_stall  = running ? (hz || ext_stall) : 1'b1;
            e_halted = !running && (m_cyc > m_halt_at + D);
            check("m_stall_pipe", {31'd0, stall_pipe}, {31'd0, e_stall});
            check("m_hold_pc", {31'd0, hold_pc}, {31'd0, e_stall});
            check("m_hold_if_id", {31'd0, hold_if_id}, {31'd0, e_stall});
            check("m_halted", {31'd0, halted}, {31'd0, e_halted});
            check("m_stall_cnt", {16'd0, stall_cnt}, m_cnt);
            if (cnt_clr) m_cnt = 0;
            else if (running && e_stall && m_cnt < MAXC) m_cnt++;
            if (running && halt_s2 && !e_stall) m_halt_at = m_cyc;
            m_cyc++;
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r1_addr = 0; r2_addr = 0; waddr_s3 = 0; r1_used = 0; r2_used = 0;
        rw_s3 = 1; sel_mem_s3 = 0; halt_s2 = 0; ext_stall = 0; cnt_clr = 0;
    endtask

    task automatic load_hazard(input logic [4:0] a);
        sel_mem_s3 = 1; rw_s3 = 0; waddr_s3 = a; r1_addr = a; r1_used = 1;
    endtask

    task automatic bubble();
        sel_mem_s3 = 0; rw_s3 = 1; waddr_s3 = 0;
    endtask

    task automatic reset_dut();
        rst_ = 0;
        idle();
        @(negedge clk);
        next();
        rst_ = 1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        @(negedge clk);
        check("reset_stall", {31'd0, stall_pipe}, 0);
        check("reset_cnt", {16'd0, stall_cnt}, 0);
        next();
        rst_ = 1;

        // Load-use on r1: one stall cycle, then the bubble clears it.
        load_hazard(5'd5);
        @(negedge clk);
        check("lu_stall", {31'd0, stall_pipe}, 1);
        check("lu_hold_pc", {31'd0, hold_pc}, 1);
        check("lu_hold_if_id", {31'd0, hold_if_id}, 1);
        next();
        bubble();
        @(negedge clk);
        check("lu_after", {31'd0, stall_pipe}, 0);
        check("lu_cnt", {16'd0, stall_cnt}, 1);

        // No-hazard cases.
        next();
        sel_mem_s3 = 1; rw_s3 = 0; waddr_s3 = 0; r2_addr = 0; r2_used = 1; r1_used = 0;
        @(negedge clk);
        check("nh_r0", {31'd0, stall_pipe}, 0);
        next();
        waddr_s3 = 7; r1_addr = 7; r1_used = 0; r2_used = 0;
        @(negedge clk);
        check("nh_unused", {31'd0, stall_pipe}, 0);
        next();
        sel_mem_s3 = 0; r1_used = 1;
        @(negedge clk);
        check("nh_alu", {31'd0, stall_pipe}, 0);

        // Randomized traffic, with periodic resets to leave HALTED.
        for (int i = 0; i < 3000; i++) begin
            next();
            if (i % 250 == 249) begin
                rst_ = 0;
                @(negedge clk);
                next();
                rst_ = 1;
            end
            r1_addr    = 5'($urandom_range(0, 3));
            r2_addr    = 5'($urandom_range(0, 3));
            waddr_s3   = 5'($urandom_range(0, 3));
            r1_used    = 1'($urandom);
            r2_used    = 1'($urandom);
            rw_s3      = 1'($urandom);
            sel_mem_s3 = 1'($urandom);
            ext_stall  = ($urandom_range(0, 3) == 0);
            halt_s2    = ($urandom_range(0, 31) == 0);
            cnt_clr    = ($urandom_range(0, 49) == 0);
        end

        // Halt drain with no hazard.
        next();
        reset_dut();
        halt_s2 = 1;
        @(negedge clk);
        check("halt_c0", {31'd0, stall_pipe}, 0);
        for (int k = 1; k <= 7; k++) begin
            next();
            halt_s2 = 0;
            @(negedge clk);
            check("halt_stall", {31'd0, stall_pipe}, 1);
            check("halt_flag", {31'd0, halted}, (k >= 4) ? 1 : 0);
        end

        // Halt coincident with load-use: stall first, drain after.
        next();
        reset_dut();
        load_hazard(5'd9);
        halt_s2 = 1;
        @(negedge clk);
        check("hh_stall", {31'd0, stall_pipe}, 1);
        next();
        bubble();
        @(negedge clk);
        check("hh_clear", {31'd0, stall_pipe}, 0);
        for (int k = 1; k <= 4; k++) begin
            next();
            halt_s2 = 0;
            @(negedge clk);
            check("hh_halted", {31'd0, halted}, (k == 4) ? 1 : 0);
        end

        // Asynchronous reset during DRAIN.
        next();
        reset_dut();
        ext_stall = 1;
        next();
        next();
        ext_stall = 0;
        halt_s2 = 1;
        next();
        halt_s2 = 0;
        @(negedge clk);
        check("rd_draining", {31'd0, stall_pipe}, 1);
        check("rd_cnt_before", {16'd0, stall_cnt}, 2);
        next();
        #2;
        rst_ = 0;
        #1;
        check("rd_async_stall", {31'd0, stall_pipe}, 0);
        check("rd_async_pc", {31'd0, hold_pc}, 0);
        check("rd_async_ifid", {31'd0, hold_if_id}, 0);
        check("rd_async_cnt", {16'd0, stall_cnt}, 0);
        @(negedge clk);
        next();
        rst_ = 1;
        @(negedge clk);
        check("rd_run_stall", {31'd0, stall_pipe}, 0);
        check("rd_run_halted", {31'd0, halted}, 0);
        next();
        ext_stall = 1;
        @(negedge clk);
        check("rd_run_responds", {31'd0, stall_pipe}, 1);
        next();
        ext_stall = 0;
        @(negedge clk);
        check("rd_run_cnt", {16'd0, stall_cnt}, 1);

        // Counter saturation and clear.
        next();
        reset_dut();
        ext_stall = 1;
        repeat (70000) next();
        @(negedge clk);
        check("cnt_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
        next();
        cnt_clr = 1;
        next();
        cnt_clr = 0;
        ext_stall = 0;
        @(negedge clk);
        check("cnt_clr", {16'd0, stall_cnt}, 0);

        next();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
